pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the IF stage; drives fetch address and chip-enable
//  to instruction memory. Adds over the single-width PC: reset vector, stall/fetch-ready handshake,
//  branch redirect with pending buffer (delay-slot semantics), exception flush and halt state.
// PARAMETERS
//  ADDR_W        32            fetch address width (bits)
//  INST_BYTES    4             PC increment per fetched instruction; power of 2
//  RESET_VECTOR  32'h00000000  pc value during and after reset
//  EXC_VECTOR    32'h00000020  unused; flush target comes from exc_target port (kept for default binding)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       reset, asynchronous, active-low (0 = reset)
//  pc             out  ADDR_W  current fetch address
//  ce             out  1       instruction memory chip enable (1 = fetch valid)
//  if_ready       in   1       memory accepts fetch at pc this cycle
//  stall          in   1       pipeline stall from control; blocks pc advance
//  halt           in   1       level request to stop fetching
//  branch_flag    in   1       redirect request, one-cycle pulse
//  branch_target  in   ADDR_W  redirect address
//  flush          in   1       exception flush, one-cycle pulse
//  exc_target     in   ADDR_W  exception handler address
//  misaligned     out  1       one-cycle pulse: a loaded target had nonzero low bits
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_VECTOR, ce=0, misaligned=0, pend_valid=0, state=S_OFF.
//  States: S_OFF, S_RUN, S_HALT. ce=1 only in S_RUN (registered, from state).
//  S_OFF -> S_RUN on first clk edge with rst=1 (halt=0); pc held, so first fetch is RESET_VECTOR.
//   S_OFF with halt=1 -> S_HALT.
//  accept = ce & if_ready & ~stall. Only on accept does pc advance.
//  Next pc on accept: branch_flag ? branch_target : pend_valid ? pend_target : pc+INST_BYTES.
//  branch_flag without accept: pend_target<=branch_target, pend_valid<=1; pc unchanged
//   (instruction at current pc is the delay slot and is still fetched).
//  Second branch_flag while pend_valid: newer target overwrites older.
//  Pending consumed (pend_valid<=0) on the accept that loads it.
//  flush: highest priority, independent of stall/if_ready/halt/state (except reset):
//   pc<=exc_target, pend_valid<=0, state<=S_RUN. Simultaneous branch_flag is dropped.
//  halt=1 in S_RUN -> S_HALT next edge; pc and pending held; ce=0. halt=0 in S_HALT -> S_RUN.
//  Alignment: every loaded target has low log2(INST_BYTES) bits forced to 0; misaligned=1 for
//   exactly the cycle after a load whose raw target had any of those bits set.
//  Arithmetic modulo 2^ADDR_W: pc=all-ones-(INST_BYTES-1) + INST_BYTES wraps to 0, no flag.
//  Reset mid-operation: immediate return to reset values, pending lost.
// STRUCTURE
//  Shared package pc_pkg: state encoding (S_OFF/S_RUN/S_HALT), ChipEnable=1/ChipDisable=0,
//   RstEnable=1'b0, default INST_BYTES and vectors.
//  Sub-module pc_redirect_buf: pending target register + valid, load/overwrite/consume/clear,
//   with alignment mask and misaligned detect. pc_gen holds FSM and pc register.
// TESTING
//  Reset release, if_ready=1: cycle0 ce=0 pc=0; then ce=1, pc=0,4,8,12 on successive edges.
//  stall=1 for 3 cycles at pc=8 -> pc stays 8, ce=1; after release pc=12.
//  branch_flag, target=0x100 at pc=0x10 with if_ready=0 -> pc holds 0x10, pending set; if_ready=1 ->
//   pc=0x100 next, then 0x104.
//  flush exc_target=0x20 with stall=1 and pend_valid=1 -> pc=0x20 next edge, pending cleared.
//  halt=1 at pc=0x40 -> ce=0, pc frozen; halt=0 -> ce=1, pc continues 0x44; branch target 0x103 ->
//   pc=0x100, misaligned pulse 1 cycle.
//  ADDR_W=8, pc=0xFC, accept -> pc=0x00; rst=0 mid-pending -> pc=RESET_VECTOR, ce=0 async.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter generator: FSM encoding,
// chip-enable / reset polarity constants and default parameter values.
package pc_pkg;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } pc_state_t;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b0;

    localparam int          DEF_ADDR_W       = 32;
    localparam int          DEF_INST_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0020;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending branch-target buffer: holds a redirect that arrived while the fetch
// was not accepted, aligns incoming targets and flags misaligned loads.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int INST_BYTES = DEF_INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] exc_target,
    output logic [ADDR_W-1:0] branch_aligned,
    output logic [ADDR_W-1:0] exc_aligned,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_target,
    output logic              misaligned
);

    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

    logic branch_mis;
    logic exc_mis;

    assign branch_aligned = branch_target & ~LOW_MASK;
    assign exc_aligned    = exc_target & ~LOW_MASK;
    assign branch_mis     = |(branch_target & LOW_MASK);
    assign exc_mis        = |(exc_target & LOW_MASK);

    // A flush drops any concurrent branch, so only its own target can be flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
            misaligned  <= 1'b0;
        end else begin
            misaligned <= flush ? exc_mis : (branch_flag & branch_mis);
            if (flush) begin
                pend_valid <= 1'b0;
            end else if (branch_flag && !accept) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_aligned;
            end else if (accept) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: reset vector, fetch-ready/stall handshake, buffered
// branch redirect with delay slot, exception flush and halt.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                INST_BYTES   = DEF_INST_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    input  logic              if_ready,
    input  logic              stall,
    input  logic              halt,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] exc_target,
    output logic              misaligned
);

    // EXC_VECTOR is only a default binding; flush targets come from exc_target.
    if (!is_pow2(INST_BYTES)) begin : g_bad_inst_bytes
        $error("pc_gen: INST_BYTES must be a power of 2");
    end
    if ((EXC_VECTOR & ADDR_W'(INST_BYTES - 1)) != '0) begin : g_bad_exc_vector
        $error("pc_gen: EXC_VECTOR must be instruction aligned");
    end

    pc_state_t         state;
    logic              accept;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_aligned;
    logic [ADDR_W-1:0] exc_aligned;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    assign accept = ce & if_ready & ~stall;

    pc_redirect_buf #(
        .ADDR_W     (ADDR_W),
        .INST_BYTES (INST_BYTES)
    ) u_redirect_buf (
        .clk            (clk),
        .rst            (rst),
        .accept         (accept),
        .branch_flag    (branch_flag),
        .branch_target  (branch_target),
        .flush          (flush),
        .exc_target     (exc_target),
        .branch_aligned (branch_aligned),
        .exc_aligned    (exc_aligned),
        .pend_valid     (pend_valid),
        .pend_target    (pend_target),
        .misaligned     (misaligned)
    );

    // A fresh branch beats an older pending one; the increment wraps modulo 2^ADDR_W.
    always_comb begin
        pc_next = pc + ADDR_W'(INST_BYTES);
        if (branch_flag) begin
            pc_next = branch_aligned;
        end else if (pend_valid) begin
            pc_next = pend_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state <= S_OFF;
            ce    <= ChipDisable;
            pc    <= RESET_VECTOR;
        end else if (flush) begin
            state <= S_RUN;
            ce    <= ChipEnable;
            pc    <= exc_aligned;
        end else begin
            if (accept) begin
                pc <= pc_next;
            end
            case (state)
                S_OFF: begin
                    if (halt) begin
                        state <= S_HALT;
                        ce    <= ChipDisable;
                    end else begin
                        state <= S_RUN;
                        ce    <= ChipEnable;
                    end
                end
                S_RUN: begin
                    if (halt) begin
                        state <= S_HALT;
                        ce    <= ChipDisable;
                    end
                end
                S_HALT: begin
                    if (!halt) begin
                        state <= S_RUN;
                        ce    <= ChipEnable;
                    end
                end
                default: begin
                    state <= S_OFF;
                    ce    <= ChipDisable;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: 32-bit instance for the main flows, 8-bit
// instance for wrap-around, halt-from-reset and asynchronous reset.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        ce;
    logic        if_ready;
    logic        stall;
    logic        halt;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] exc_target;
    logic        misaligned;

    logic        rst8;
    logic [7:0]  pc8;
    logic        ce8;
    logic        if_ready8;
    logic        stall8;
    logic        halt8;
    logic        branch8;
    logic [7:0]  branch_target8;
    logic        flush8;
    logic [7:0]  exc_target8;
    logic        misaligned8;

    int vectors;
    int miscompares;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .ce            (ce),
        .if_ready      (if_ready),
        .stall         (stall),
        .halt          (halt),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .exc_target    (exc_target),
        .misaligned    (misaligned)
    );

    pc_gen #(
        .ADDR_W       (8),
        .INST_BYTES   (4),
        .RESET_VECTOR (8'h00),
        .EXC_VECTOR   (8'h20)
    ) dut8 (
        .clk           (clk),
        .rst           (rst8),
        .pc            (pc8),
        .ce            (ce8),
        .if_ready      (if_ready8),
        .stall         (stall8),
        .halt          (halt8),
        .branch_flag   (branch8),
        .branch_target (branch_target8),
        .flush         (flush8),
        .exc_target    (exc_target8),
        .misaligned    (misaligned8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL reset_ce: got %b expected 0", ce); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_mis: got %b expected 0", misaligned); end
        rst = 1'b1;
        #1;
        vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL cycle0_ce: got %b expected 0", ce); end
        step();
        vectors++; if (ce !== 1'b1) begin miscompares++; $display("FAIL first_fetch_ce: got %b expected 1", ce); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL first_fetch_pc: got %0h expected 0", pc); end
        step();
        vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL seq_pc4: got %0h expected 4", pc); end
        step();
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL seq_pc8: got %0h expected 8", pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL stall_pc[%0d]: got %0h expected 8", i, pc); end
            vectors++; if (ce !== 1'b1) begin miscompares++; $display("FAIL stall_ce[%0d]: got %b expected 1", i, ce); end
        end
        stall = 1'b0;
        step();
        vectors++; if (pc !== 32'hC) begin miscompares++; $display("FAIL stall_release: got %0h expected c", pc); end
        step();
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL seq_pc10: got %0h expected 10", pc); end
    endtask

    task automatic test_branch_pending();
        if_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h100;
        step();
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL delay_slot_hold: got %0h expected 10", pc); end
        branch_flag = 1'b0;
        step();
        vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL pend_wait: got %0h expected 10", pc); end
        if_ready = 1'b1;
        step();
        vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL pend_load: got %0h expected 100", pc); end
        step();
        vectors++; if (pc !== 32'h104) begin miscompares++; $display("FAIL pend_consumed: got %0h expected 104", pc); end
        if_ready = 1'b0; branch_flag = 1'b1; branch_target = 32'h200;
        step();
        branch_target = 32'h300;
        step();
        vectors++; if (pc !== 32'h104) begin miscompares++; $display("FAIL overwrite_hold: got %0h expected 104", pc); end
        branch_flag = 1'b0; if_ready = 1'b1;
        step();
        vectors++; if (pc !== 32'h300) begin miscompares++; $display("FAIL overwrite_newest: got %0h expected 300", pc); end
        step();
        vectors++; if (pc !== 32'h304) begin miscompares++; $display("FAIL overwrite_next: got %0h expected 304", pc); end
    endtask

    task automatic test_flush();
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h500;
        step();
        vectors++; if (pc !== 32'h304) begin miscompares++; $display("FAIL stall_branch_hold: got %0h expected 304", pc); end
        branch_flag = 1'b0; flush = 1'b1; exc_target = 32'h20;
        step();
        vectors++; if (pc !== 32'h20) begin miscompares++; $display("FAIL flush_under_stall: got %0h expected 20", pc); end
        vectors++; if (ce !== 1'b1) begin miscompares++; $display("FAIL flush_ce: got %b expected 1", ce); end
        flush = 1'b0; stall = 1'b0;
        step();
        vectors++; if (pc !== 32'h24) begin miscompares++; $display("FAIL flush_clears_pend: got %0h expected 24", pc); end
        flush = 1'b1; exc_target = 32'h60; branch_flag = 1'b1; branch_target = 32'h700;
        step();
        vectors++; if (pc !== 32'h60) begin miscompares++; $display("FAIL flush_beats_branch: got %0h expected 60", pc); end
        flush = 1'b0; branch_flag = 1'b0;
        step();
        vectors++; if (pc !== 32'h64) begin miscompares++; $display("FAIL branch_dropped: got %0h expected 64", pc); end
    endtask

    task automatic test_halt_misaligned();
        flush = 1'b1; exc_target = 32'h42;
        step();
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL exc_align: got %0h expected 40", pc); end
        vectors++; if (misaligned !== 1'b1) begin miscompares++; $display("FAIL exc_mis: got %b expected 1", misaligned); end
        flush = 1'b0; halt = 1'b1;
        step();
        vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL halt_ce: got %b expected 0", ce); end
        vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL halt_entry_pc: got %0h expected 44", pc); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL mis_one_cycle: got %b expected 0", misaligned); end
        step();
        vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL halt_frozen: got %0h expected 44", pc); end
        vectors++; if (ce !== 1'b0) begin miscompares++; $display("FAIL halt_ce_held: got %b expected 0", ce); end
        halt = 1'b0;
        step();
        vectors++; if (ce !== 1'b1) begin miscompares++; $display("FAIL resume_ce: got %b expected 1", ce); end
        vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL resume_pc: got %0h expected 44", pc); end
        step();
        vectors++; if (pc !== 32'h48) begin miscompares++; $display("FAIL resume_next: got %0h expected 48", pc); end
        branch_flag = 1'b1; branch_target = 32'h103;
        step();
        vectors++; if (pc !== 32'h100) begin miscompares++; $display("FAIL branch_align: got %0h expected 100", pc); end
        vectors++; if (misaligned !== 1'b1) begin miscompares++; $display("FAIL branch_mis: got %b expected 1", misaligned); end
        branch_flag = 1'b0;
        step();
        vectors++; if (pc !== 32'h104) begin miscompares++; $display("FAIL after_mis_pc: got %0h expected 104", pc); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL branch_mis_clear: got %b expected 0", misaligned); end
    endtask

    task automatic test_wrap_and_async_reset();
        rst8 = 1'b1; halt8 = 1'b1;
        step();
        vectors++; if (ce8 !== 1'b0) begin miscompares++; $display("FAIL off_to_halt_ce: got %b expected 0", ce8); end
        halt8 = 1'b0;
        step();
        vectors++; if (ce8 !== 1'b1) begin miscompares++; $display("FAIL halt_to_run_ce: got %b expected 1", ce8); end
        vectors++; if (pc8 !== 8'h00) begin miscompares++; $display("FAIL w8_first_pc: got %0h expected 0", pc8); end
        flush8 = 1'b1; exc_target8 = 8'hFC;
        step();
        vectors++; if (pc8 !== 8'hFC) begin miscompares++; $display("FAIL w8_flush: got %0h expected fc", pc8); end
        flush8 = 1'b0;
        step();
        vectors++; if (pc8 !== 8'h00) begin miscompares++; $display("FAIL w8_wrap: got %0h expected 0", pc8); end
        vectors++; if (misaligned8 !== 1'b0) begin miscompares++; $display("FAIL w8_wrap_noflag: got %b expected 0", misaligned8); end
        step();
        vectors++; if (pc8 !== 8'h04) begin miscompares++; $display("FAIL w8_after_wrap: got %0h expected 4", pc8); end
        if_ready8 = 1'b0; branch8 = 1'b1; branch_target8 = 8'h80;
        step();
        vectors++; if (pc8 !== 8'h04) begin miscompares++; $display("FAIL w8_pend_hold: got %0h expected 4", pc8); end
        branch8 = 1'b0;
        #1 rst8 = 1'b0;
        #1;
        vectors++; if (pc8 !== 8'h00) begin miscompares++; $display("FAIL async_rst_pc: got %0h expected 0", pc8); end
        vectors++; if (ce8 !== 1'b0) begin miscompares++; $display("FAIL async_rst_ce: got %b expected 0", ce8); end
        rst8 = 1'b1; if_ready8 = 1'b1;
        step();
        vectors++; if (ce8 !== 1'b1 || pc8 !== 8'h00) begin miscompares++; $display("FAIL rerun_first: got ce=%b pc=%0h expected ce=1 pc=0", ce8, pc8); end
        step();
        vectors++; if (pc8 !== 8'h04) begin miscompares++; $display("FAIL pend_lost: got %0h expected 4", pc8); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; if_ready = 1'b1; stall = 1'b0; halt = 1'b0;
        branch_flag = 1'b0; branch_target = '0; flush = 1'b0; exc_target = '0;
        rst8 = 1'b0; if_ready8 = 1'b1; stall8 = 1'b0; halt8 = 1'b0;
        branch8 = 1'b0; branch_target8 = '0; flush8 = 1'b0; exc_target8 = '0;
        test_reset();
        test_stall();
        test_branch_pending();
        test_flush();
        test_halt_misaligned();
        test_wrap_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
